// File: rtl/rr_grant_ctrl.sv
// Round-robin single-owner arbiter with hold-until-release grants and optional
// timeout preemption. The winner index is the parallel encoding of the one-hot grant.

module encoder_paral #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] oh,
    output logic [W-1:0] bin
);
    // Output bit b is the OR of every one-hot input whose index has bit b set.
    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [N-1:0] m;
        for (genvar i = 0; i < N; i++) begin : g_in
            assign m[i] = (((i >> b) & 1) == 1) ? oh[i] : 1'b0;
        end
        assign bin[b] = |m;
    end
endmodule

module rr_grant_ctrl #(
    parameter int N        = 8,
    parameter int W        = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id,
    output logic         gnt_vld,
    output logic         preempt
);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_n;
    logic [N-1:0]   gnt_q, gnt_n;
    logic [W-1:0]   ptr_q, ptr_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic           preempt_q, preempt_n;

    logic [N-1:0]   idle_gnt, rel_gnt, pre_gnt;
    logic [W-1:0]   rel_ptr, pre_id;

    function automatic logic [W-1:0] inc_wrap(input logic [W-1:0] p);
        return (int'(p) == N - 1) ? '0 : W'(int'(p) + 1);
    endfunction

    // First set bit of m scanning p, p+1, ..., N-1, 0, ..., p-1.
    function automatic logic [N-1:0] sel(input logic [W-1:0] p, input logic [N-1:0] m);
        logic [N-1:0] r;
        logic         found;
        int           idx;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(p) + k;
            if (idx >= N) idx = idx - N;
            if (!found && m[idx]) begin
                r[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return r;
    endfunction

    encoder_paral #(.N(N), .W(W)) u_enc_gnt (.oh(gnt_q),   .bin(gnt_id));
    encoder_paral #(.N(N), .W(W)) u_enc_pre (.oh(pre_gnt), .bin(pre_id));

    // Candidates are computed outside the FSM so the preempt pointer can use
    // the encoded next owner without a combinational loop.
    assign idle_gnt = sel(ptr_q, req);
    assign rel_ptr  = inc_wrap(gnt_id);
    assign rel_gnt  = sel(rel_ptr, req);
    assign pre_gnt  = sel(rel_ptr, req & ~gnt_q);

    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        ptr_n     = ptr_q;
        cnt_n     = cnt_q;
        preempt_n = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_n = '0;
                if (|req) begin
                    gnt_n   = idle_gnt;
                    cnt_n   = CW'(1);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (req[gnt_id]) begin
                    if (MAX_HOLD == 0 || cnt_q < CW'(MAX_HOLD)) begin
                        cnt_n = cnt_q + 1'b1;
                    end else if (|(req & ~gnt_q)) begin
                        gnt_n     = pre_gnt;
                        ptr_n     = inc_wrap(pre_id);
                        cnt_n     = CW'(1);
                        preempt_n = 1'b1;
                    end else begin
                        cnt_n = CW'(1);
                    end
                end else begin
                    ptr_n = rel_ptr;
                    gnt_n = rel_gnt;
                    if (|req) begin
                        cnt_n = CW'(1);
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            gnt_q     <= gnt_n;
            ptr_q     <= ptr_n;
            cnt_q     <= cnt_n;
            preempt_q <= preempt_n;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = |gnt_q;
    assign preempt = preempt_q;
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scenario bench for rr_grant_ctrl: N=4/MAX_HOLD=3 main instance plus an N=5
// instance for non-power-of-two wrap-around.

module tb_rr_grant_ctrl;
    logic       clk;
    logic       rst_n, rst5_n;
    logic [3:0] req;
    logic [4:0] req5;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld, preempt;
    logic [4:0] gnt5;
    logic [2:0] gnt_id5;
    logic       gnt_vld5, preempt5;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       pre;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    rr_grant_ctrl #(.N(4), .MAX_HOLD(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .preempt(preempt)
    );

    rr_grant_ctrl #(.N(5), .MAX_HOLD(3)) dut5 (
        .clk(clk), .rst_n(rst5_n), .req(req5),
        .gnt(gnt5), .gnt_id(gnt_id5), .gnt_vld(gnt_vld5), .preempt(preempt5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic vld, input logic pre);
        exp_t x;
        x.gnt = vld ? 4'(1 << id) : 4'b0000;
        x.id  = vld ? 2'(id) : 2'd0;
        x.vld = vld;
        x.pre = pre;
        sbq.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 1'b0, 1'b0);
            tick();
            e = sbq.pop_front();
            tests++;
            if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
                fails++;
                $display("FAIL reset[%0d] got gnt=%b id=%0d vld=%b pre=%b want gnt=%b id=%0d vld=%b pre=%b",
                         i, gnt, gnt_id, gnt_vld, preempt, e.gnt, e.id, e.vld, e.pre);
            end
        end
        rst_n = 1'b1;
        push_exp(0, 1'b1, 1'b0);
        tick();
        e = sbq.pop_front();
        tests++;
        if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
            fails++;
            $display("FAIL reset_release got gnt=%b id=%0d vld=%b pre=%b want gnt=%b id=%0d",
                     gnt, gnt_id, gnt_vld, preempt, e.gnt, e.id);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req = (i < 10) ? 4'b0100 : 4'b0000;
            push_exp(2, i < 10, 1'b0);
            tick();
            e = sbq.pop_front();
            tests++;
            if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
                fails++;
                $display("FAIL single[%0d] got gnt=%b id=%0d vld=%b pre=%b want gnt=%b id=%0d vld=%b pre=%b",
                         i, gnt, gnt_id, gnt_vld, preempt, e.gnt, e.id, e.vld, e.pre);
            end
        end
        tests++;
        if (dut.ptr_q !== 2'd3) begin
            fails++;
            $display("FAIL single_ptr got %0d want 3", dut.ptr_q);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rv[6] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000};
        int         eid[6] = '{0, 1, 2, 3, 0, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = rv[i];
            push_exp(eid[i], i < 5, 1'b0);
            tick();
            e = sbq.pop_front();
            tests++;
            if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
                fails++;
                $display("FAIL round_robin[%0d] got gnt=%b id=%0d vld=%b pre=%b want gnt=%b id=%0d vld=%b pre=%b",
                         i, gnt, gnt_id, gnt_vld, preempt, e.gnt, e.id, e.vld, e.pre);
            end
        end
    endtask

    task automatic test_preempt();
        int   eid[10]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        logic epre[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            push_exp(eid[i], 1'b1, epre[i]);
            tick();
            e = sbq.pop_front();
            tests++;
            if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
                fails++;
                $display("FAIL preempt[%0d] got gnt=%b id=%0d vld=%b pre=%b want gnt=%b id=%0d vld=%b pre=%b",
                         i, gnt, gnt_id, gnt_vld, preempt, e.gnt, e.id, e.vld, e.pre);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] rv[2] = '{4'b0100, 4'b0011};
        int         eid[2] = '{2, 0};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            req = rv[i];
            push_exp(eid[i], 1'b1, 1'b0);
            tick();
            e = sbq.pop_front();
            tests++;
            if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
                fails++;
                $display("FAIL wrap4[%0d] got gnt=%b id=%0d vld=%b pre=%b want gnt=%b id=%0d",
                         i, gnt, gnt_id, gnt_vld, preempt, e.gnt, e.id);
            end
        end
        tests++;
        if (dut.ptr_q !== 2'd3) begin
            fails++;
            $display("FAIL wrap4_ptr got %0d want 3", dut.ptr_q);
        end
        // Five-requester instance: owner 3 releases, pointer lands on 4, wraps to 0.
        rst5_n = 1'b0;
        req5   = 5'b00000;
        tick();
        rst5_n = 1'b1;
        req5   = 5'b01000;
        tick();
        tests++;
        if (gnt5 !== 5'b01000 || gnt_id5 !== 3'd3) begin
            fails++;
            $display("FAIL wrap5_first got gnt=%b id=%0d want gnt=01000 id=3", gnt5, gnt_id5);
        end
        req5 = 5'b00011;
        tick();
        tests++;
        if (gnt5 !== 5'b00001 || gnt_id5 !== 3'd0 || gnt_vld5 !== 1'b1 || preempt5 !== 1'b0) begin
            fails++;
            $display("FAIL wrap5_next got gnt=%b id=%0d vld=%b pre=%b want gnt=00001 id=0 vld=1 pre=0",
                     gnt5, gnt_id5, gnt_vld5, preempt5);
        end
        tests++;
        if (dut5.ptr_q !== 3'd4) begin
            fails++;
            $display("FAIL wrap5_ptr got %0d want 4", dut5.ptr_q);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] rv[2] = '{4'b0010, 4'b0011};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            req = rv[i];
            push_exp(1, 1'b1, 1'b0);
            tick();
            e = sbq.pop_front();
            tests++;
            if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
                fails++;
                $display("FAIL reset_mid_setup[%0d] got gnt=%b id=%0d pre=%b want gnt=%b id=%0d",
                         i, gnt, gnt_id, preempt, e.gnt, e.id);
            end
        end
        rst_n = 1'b0;
        push_exp(0, 1'b0, 1'b0);
        tick();
        e = sbq.pop_front();
        tests++;
        if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
            fails++;
            $display("FAIL reset_mid_drop got gnt=%b id=%0d vld=%b pre=%b want all zero",
                     gnt, gnt_id, gnt_vld, preempt);
        end
        rst_n = 1'b1;
        push_exp(0, 1'b1, 1'b0);
        tick();
        e = sbq.pop_front();
        tests++;
        if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || preempt !== e.pre) begin
            fails++;
            $display("FAIL reset_mid_regrant got gnt=%b id=%0d pre=%b want gnt=%b id=%0d",
                     gnt, gnt_id, preempt, e.gnt, e.id);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst5_n = 1'b0;
        req    = 4'b0000;
        req5   = 5'b00000;
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_wrap();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter that shares one downstream resource among `N` requesters with a hold-until-release grant and optional preemption after a bounded hold time. The winner's index comes from the codebase's parallel one-hot-to-binary encoder (`encoder_paral`) applied to the one-hot grant vector. The block sits in front of any shared datapath that needs sequenced, fair, single-owner access.

## Interface
- `N`, 8: number of requesters, at least 2, need not be a power of two.
- `W`, `$clog2(N)`: index width.
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may be held while others wait. 0 means unlimited, so the block never preempts.

- `clk`  in  1  clock. All logic is on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `req`  in  N  request vector. `req[i]` stays high for as long as requester i wants or holds the resource.
- `gnt`  out  N  registered grant, one-hot or zero.
- `gnt_id`  out  W  binary index of the set bit of `gnt`. It is the encoder output of `gnt` and is 0 when `gnt` is 0.
- `gnt_vld`  out  1  equals `|gnt`.
- `preempt`  out  1  one-cycle pulse in the first cycle after a grant was taken away by a timeout.

## Operation
- **States**
  - IDLE: no grant.
  - BUSY: grant held.
- **Internal registers**
  - Priority pointer `ptr`, W bits, range 0..N-1.
  - Hold counter `cnt`, wide enough to hold `MAX_HOLD`.
- **Selection function `sel(p, mask)`**
  - Returns the first set bit of `req & mask`, scanning indices p, p+1, …, N-1, 0, …, p-1.
  - Wrap-around is at N-1 to 0, including when N is not a power of two.
- **IDLE**
  - If `req` is nonzero: grant `sel(ptr, all)`, load `cnt` = 1, go to BUSY.
  - Otherwise stay in IDLE with `gnt` = 0.
- **BUSY, holder still requesting** (`req[gnt_id]` = 1)
  - If `MAX_HOLD` = 0, or `cnt` < `MAX_HOLD`: keep the grant and increment `cnt`.
  - If `cnt` == `MAX_HOLD` and some other requester is active:
    - Grant `sel(gnt_id+1, ~gnt)`.
    - Set `ptr` to the new grant index + 1.
    - Load `cnt` = 1.
    - Assert `preempt` for the next cycle.
  - If `cnt` == `MAX_HOLD` and no other requester is active: keep the grant, reload `cnt` = 1, no `preempt`.
- **BUSY, holder released** (`req[gnt_id]` = 0)
  - Set `ptr` to `gnt_id`+1 mod N.
  - Re-arbitrate in the same edge using the updated pointer. There is no dead cycle between owners.
  - If no other request is active: `gnt` becomes 0 and the state goes to IDLE.
- **Pointer update on a new grant from IDLE:** `ptr` is unchanged at grant time. It advances only on release or preemption.
- **Grant invariants**
  - At most one bit of `gnt` is set.
  - A requester never receives a grant while its `req` is 0.
- **Reset mid-grant:** the grant drops at that edge. No `preempt` pulse is produced.

## Timing
- **Reset values:** `gnt` = 0, `gnt_id` = 0, `gnt_vld` = 0, `preempt` = 0, `ptr` = 0, `cnt` = 0, state IDLE.
- **Reset is synchronous:** the values above appear after the first rising edge with `rst_n` = 0 and hold while `rst_n` = 0.
- **Request to grant latency:** 1 cycle. A `req` sampled high at edge k gives `gnt` valid after edge k.
- **Release to next grant:** 1 cycle. A `req[gnt_id]` sampled low at edge k moves the grant to the next requester, or to 0, after edge k.
- **Bounded hold:** with competition, a holder sees `gnt_vld` for exactly `MAX_HOLD` cycles before preemption.
- **`preempt` alignment:** the pulse is coincident with the first cycle of the new owner's grant.
- **Combinational paths:** none from inputs to outputs. All outputs are registered, and `gnt_id` is the encoder applied to registered `gnt`.

## Test plan
All scenarios use `N` = 4 and `MAX_HOLD` = 3 unless stated otherwise.

1. **Reset:** drive `rst_n` = 0 for 3 cycles with `req` = 4'b1111. Required: all outputs stay 0. One cycle after `rst_n` rises, `gnt` = 4'b0001 and `gnt_id` = 0.
2. **Single requester:** `req` = 4'b0100 for 10 cycles, then 0.
   - Required: `gnt` = 4'b0100 and `gnt_id` = 2 from cycle 1 through cycle 10, with no `preempt`.
   - Required: `gnt` = 0 one cycle after the drop, and internal `ptr` = 3.
3. **Round-robin fairness:** `req` = 4'b1111, and each owner drops its `req` for one cycle in its first grant cycle, then re-raises it. Required grant sequence: 0, 1, 2, 3, 0, with no gaps.
4. **Preemption:** `req` = 4'b0011 held constant.
   - Required pattern: `gnt_id` 0 for 3 cycles, then 1 for 3 cycles, then 0, repeating.
   - Required: `preempt` = 1 in the first cycle of each new grant.
5. **Wrap-around:** grant index 2, then have it release so `ptr` = 3, with `req` = 4'b0011 at the release edge. Required: next `gnt_id` = 0, not 1. Repeat with `N` = 5, `ptr` = 4, `req` = 5'b00011: required next `gnt_id` = 0.
6. **Reset mid-grant:** assert `rst_n` = 0 in the second cycle of a grant to index 1 under contention. Required: `gnt` = 0 and `preempt` = 0 after that edge, and the first grant after reset goes to the lowest requesting index.
